if_stage: RTL

Instruction-fetch stage of the MIPS 5-stage pipeline. Holds the PC and runs a variable-latency instruction-memory handshake. Drives the IF/ID pipeline register whose `inst_id` feeds the decode controller. Applies the controller's `pc_src` redirects (jump, jr, branch) and obeys its per-stage enable/reset signals and load-use stalls.

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_next_pc.sv | 22 ++
 rtl/if_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes
// (also used by the decode controller) and the branch-offset helper.
package if_stage_pkg;

  localparam logic [2:0] PC_NEXT   = 3'd0;
  localparam logic [2:0] PC_JUMP   = 3'd1;
  localparam logic [2:0] PC_JR     = 3'd2;
  localparam logic [2:0] PC_BRANCH = 3'd3;

  // Sign-extended 16-bit immediate scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{16{imm[15]}}, imm};
    return off <<< 2;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational redirect-target calculation for the instruction held in ID.
module if_next_pc
  import if_stage_pkg::*;
(
  input  logic [2:0]  pc_src,
  input  logic [25:0] instr_index,
  input  logic [31:0] pc_next_id,
  input  logic [31:0] data_rs,
  output logic [31:0] target
);

  always_comb begin
    target = pc_next_id;
    case (pc_src)
      PC_JUMP:   target = {pc_next_id[31:28], instr_index, 2'b00};
      PC_JR:     target = data_rs;
      PC_BRANCH: target = pc_next_id + branch_offset(instr_index[15:0]);
      default:   target = pc_next_id;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, variable-latency imem handshake, IF/ID register.
// Define DELAY_SLOT_EN to keep the word after a taken redirect (branch delay slot).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        id_rst,
  input  logic        id_en,
  input  logic [2:0]  pc_src,
  input  logic [31:0] data_rs,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic        if_valid,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_next_id,
  output logic        id_valid
);

`ifdef DELAY_SLOT_EN
  localparam bit SQUASH_EN = 1'b0;
`else
  localparam bit SQUASH_EN = 1'b1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} fetch_state_t;

  fetch_state_t state;
  logic         redir_pend;
  logic [31:0]  redir_pc;
  logic [31:0]  hold_buf;
  logic [31:0]  target;
  logic         advance, redirect, word_rdy, squash, deliver, take;
  logic [31:0]  word, pc_after;

  if_next_pc u_next_pc (
    .pc_src      (pc_src),
    .instr_index (inst_id[25:0]),
    .pc_next_id  (pc_next_id),
    .data_rs     (data_rs),
    .target      (target)
  );

  assign advance  = if_en & id_en;
  assign redirect = id_valid & advance & (pc_src != PC_NEXT);
  assign word_rdy = ~(rst | if_rst) &
                    (((state == S_WAIT) & imem_ready) | (state == S_HOLD));
  // Without delay slots the word behind a redirect is on the wrong path.
  assign squash   = SQUASH_EN & (redir_pend | redirect);
  assign deliver  = word_rdy & advance & ~squash;
  assign take     = word_rdy & (advance | squash);
  assign word     = (state == S_HOLD) ? hold_buf : imem_rdata;
  assign pc_after = redir_pend ? redir_pc : (redirect ? target : pc_if + 32'd4);

  assign imem_req   = (state == S_WAIT);
  assign imem_addr  = pc_if;
  assign if_valid   = word_rdy & ~squash;
  assign pc_next_id = pc_id + 32'd4;

  // Fetch FSM, PC and hold buffer
  always_ff @(posedge clk) begin
    if (rst | if_rst) begin
      state      <= S_IDLE;
      pc_if      <= RESET_PC;
      redir_pend <= 1'b0;
      redir_pc   <= RESET_PC;
      hold_buf   <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: begin
          if (imem_ready) begin
            if (take) begin
              pc_if      <= pc_after;
              redir_pend <= 1'b0;
            end else begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            redir_pend <= 1'b1;
            redir_pc   <= target;
          end
        end
        S_HOLD: begin
          if (advance) begin
            pc_if      <= pc_after;
            redir_pend <= 1'b0;
            hold_buf   <= '0;
            state      <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IF/ID register: reset beats load, bubbles whenever no word is delivered
  always_ff @(posedge clk) begin
    if (rst | id_rst) begin
      inst_id  <= '0;
      pc_id    <= '0;
      id_valid <= 1'b0;
    end else if (advance) begin
      if (deliver) begin
        inst_id  <= word;
        pc_id    <= pc_if;
        id_valid <= 1'b1;
      end else begin
        inst_id  <= '0;
        id_valid <= 1'b0;
      end
    end
  end

endmodule
